// File: rtl/lsu_controller_if.sv
// Data-memory bus bundle between the load/store unit (master) and the memory (slave).
// Signal names keep the LSU-side direction suffixes so they read the same at both ends.
interface lsu_controller_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        input  mem_rd_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
        output mem_rd_i, mem_ready_i
    );
endinterface

// File: rtl/lsu_controller.sv
// Load/store unit: one data-bus transaction per memory instruction via IDLE/REQ/DONE FSM.
// Optional macro LSU_MISALIGN_EN: trap misaligned H/W accesses without touching the bus.
module lsu_controller #(
    parameter int BUS_TIMEOUT = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    core_req_i,
    input  logic                    core_we_i,
    input  logic [2:0]              core_size_i,
    input  logic [31:0]             core_addr_i,
    input  logic [31:0]             core_wd_i,
    output logic [31:0]             core_rd_o,
    output logic                    core_stall_o,
    output logic                    bus_err_o,
    output logic                    misalign_o,
    lsu_controller_if.master        bus
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

    state_t         state_q;
    logic [2:0]     size_q;
    logic [1:0]     off_q;
    logic [CW-1:0]  cnt_q;
    logic           mem_req_q;
    logic           mem_we_q;
    logic [3:0]     mem_be_q;
    logic [31:0]    mem_addr_q;
    logic [31:0]    mem_wd_q;
    logic [31:0]    core_rd_q;
    logic           bus_err_q;

    logic [3:0]     be_d;
    logic [31:0]    wd_d;
    logic           timeout_hit;
    logic           misaligned;

    function automatic logic [31:0] extract(input logic [2:0]  size,
                                            input logic [1:0]  off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (size)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            3'b010:  return w;
            default: return 32'b0;
        endcase
    endfunction

    always_comb begin
        be_d = 4'b0000;
        wd_d = core_wd_i;
        case (core_size_i)
            3'b000, 3'b100: begin
                be_d = 4'b0001 << core_addr_i[1:0];
                wd_d = {4{core_wd_i[7:0]}};
            end
            3'b001, 3'b101: begin
                be_d = 4'b0011 << {core_addr_i[1], 1'b0};
                wd_d = {2{core_wd_i[15:0]}};
            end
            3'b010:  be_d = 4'b1111;
            default: be_d = 4'b0000;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    logic misalign_q;
    assign misaligned = (((core_size_i == 3'b001) || (core_size_i == 3'b101)) && core_addr_i[0])
                     || ((core_size_i == 3'b010) && (core_addr_i[1:0] != 2'b00));
    assign misalign_o = misalign_q;
`else
    assign misaligned = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // BUS_TIMEOUT=0 disables the abort path entirely.
    assign timeout_hit = (BUS_TIMEOUT > 0) && (cnt_q == CW'(BUS_TIMEOUT - 1));

    always_comb begin
        case (state_q)
            IDLE:    core_stall_o = core_req_i;
            REQ:     core_stall_o = 1'b1;
            default: core_stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            size_q     <= 3'b000;
            off_q      <= 2'b00;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_be_q   <= 4'b0000;
            mem_addr_q <= 32'b0;
            mem_wd_q   <= 32'b0;
            core_rd_q  <= 32'b0;
            bus_err_q  <= 1'b0;
`ifdef LSU_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            bus_err_q <= 1'b0;
`ifdef LSU_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (core_req_i) begin
                        if (misaligned) begin
`ifdef LSU_MISALIGN_EN
                            misalign_q <= 1'b1;
`endif
                            core_rd_q <= 32'b0;
                            state_q   <= DONE;
                        end else begin
                            size_q     <= core_size_i;
                            off_q      <= core_addr_i[1:0];
                            cnt_q      <= '0;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= core_we_i;
                            mem_be_q   <= be_d;
                            mem_addr_q <= {core_addr_i[31:2], 2'b00};
                            mem_wd_q   <= wd_d;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Ready on the limit cycle still completes normally.
                    if (bus.mem_ready_i) begin
                        if (!mem_we_q) begin
                            core_rd_q <= extract(size_q, off_q, bus.mem_rd_i);
                        end
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        core_rd_q <= 32'b0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_rd_o      = core_rd_q;
    assign bus_err_o      = bus_err_q;
    assign bus.mem_req_o  = mem_req_q;
    assign bus.mem_we_o   = mem_we_q;
    assign bus.mem_be_o   = mem_be_q;
    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_wd_o   = mem_wd_q;
endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: instance A without timeout, instance B with BUS_TIMEOUT=4.
module tb_lsu_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req, c_we, rdy;
    logic [2:0]  c_size;
    logic [31:0] c_addr, c_wd, rdata;
    int          sel;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    logic        a_req, b_req;
    logic [31:0] a_rd, b_rd;
    logic        a_stall, b_stall, a_err, b_err, a_mis, b_mis;

    assign a_req = c_req & (sel == 0);
    assign b_req = c_req & (sel == 1);

    lsu_controller_if bus_a ();
    lsu_controller_if bus_b ();
    assign bus_a.mem_ready_i = rdy & (sel == 0);
    assign bus_b.mem_ready_i = rdy & (sel == 1);
    assign bus_a.mem_rd_i    = rdata;
    assign bus_b.mem_rd_i    = rdata;

    lsu_controller #(.BUS_TIMEOUT(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .core_req_i(a_req), .core_we_i(c_we),
        .core_size_i(c_size), .core_addr_i(c_addr), .core_wd_i(c_wd),
        .core_rd_o(a_rd), .core_stall_o(a_stall), .bus_err_o(a_err),
        .misalign_o(a_mis), .bus(bus_a.master)
    );

    lsu_controller #(.BUS_TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .core_req_i(b_req), .core_we_i(c_we),
        .core_size_i(c_size), .core_addr_i(c_addr), .core_wd_i(c_wd),
        .core_rd_o(b_rd), .core_stall_o(b_stall), .bus_err_o(b_err),
        .misalign_o(b_mis), .bus(bus_b.master)
    );

    logic        v_stall, v_err, v_mis, v_mreq, v_mwe;
    logic [31:0] v_rd, v_addr, v_wd;
    logic [3:0]  v_be;

    always_comb begin
        v_stall = (sel == 1) ? b_stall : a_stall;
        v_err   = (sel == 1) ? b_err   : a_err;
        v_mis   = (sel == 1) ? b_mis   : a_mis;
        v_rd    = (sel == 1) ? b_rd    : a_rd;
        v_mreq  = (sel == 1) ? bus_b.mem_req_o  : bus_a.mem_req_o;
        v_mwe   = (sel == 1) ? bus_b.mem_we_o   : bus_a.mem_we_o;
        v_be    = (sel == 1) ? bus_b.mem_be_o   : bus_a.mem_be_o;
        v_addr  = (sel == 1) ? bus_b.mem_addr_o : bus_a.mem_addr_o;
        v_wd    = (sel == 1) ? bus_b.mem_wd_o   : bus_a.mem_wd_o;
    end

    int          obs_stall;
    logic        obs_err, obs_mis, obs_we;
    logic [31:0] obs_rd, obs_addr, obs_wd;
    logic [3:0]  obs_be;

    // Runs one access starting #1 after a rising edge; ready is raised after 'delay' idle REQ cycles.
    task automatic run(input logic we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int delay);
        int  reqc;
        bit  done;
        reqc = 0; done = 0; obs_stall = 0;
        obs_be = 4'hx; obs_addr = 'x; obs_wd = 'x; obs_we = 1'bx;
        c_we = we; c_size = size; c_addr = addr; c_wd = wd; rdata = rd; rdy = 1'b0;
        c_req = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (v_mreq) begin
                rdy = (reqc == delay);
                reqc++;
                obs_be = v_be; obs_addr = v_addr; obs_wd = v_wd; obs_we = v_mwe;
            end
            #1;
            if (v_stall) begin
                obs_stall++;
            end else begin
                done = 1;
                obs_rd = v_rd; obs_err = v_err; obs_mis = v_mis;
                c_req = 1'b0; rdy = 1'b0;
            end
            @(posedge clk); #1;
        end
        tests++;
        if (!done) begin
            $display("FAIL access_bound: got no retire within 40 cycles, required retire");
            fails++;
            c_req = 1'b0; rdy = 1'b0;
        end
    endtask

    task automatic test_reset();
        sel = 0; rst = 1'b1; c_req = 1'b1; c_we = 1'b0; c_size = 3'b010;
        c_addr = 32'h0; c_wd = 32'h0; rdata = 32'h0; rdy = 1'b0;
        #1;
        tests++; if (v_stall !== 1'b1) begin $display("FAIL rst_stall_req: got %b required 1", v_stall); fails++; end
        tests++; if (v_mreq !== 1'b0) begin $display("FAIL rst_mem_req: got %b required 0", v_mreq); fails++; end
        tests++; if (v_be !== 4'b0) begin $display("FAIL rst_be: got %h required 0", v_be); fails++; end
        tests++; if (v_addr !== 32'b0 || v_wd !== 32'b0) begin $display("FAIL rst_addr_wd: got %h/%h required 0/0", v_addr, v_wd); fails++; end
        tests++; if (v_rd !== 32'b0 || v_err !== 1'b0 || v_mis !== 1'b0) begin $display("FAIL rst_rd_err: got %h/%b/%b required 0/0/0", v_rd, v_err, v_mis); fails++; end
        c_req = 1'b0; #1;
        tests++; if (v_stall !== 1'b0) begin $display("FAIL rst_stall_idle: got %b required 0", v_stall); fails++; end
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] reset checks done");
    endtask

    task automatic test_store();
        sel = 0;
        run(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
        tests++; if (obs_be !== 4'b1111 || obs_addr !== 32'h104) begin $display("FAIL sw_be_addr: got %h/%h required f/00000104", obs_be, obs_addr); fails++; end
        tests++; if (obs_wd !== 32'hDEAD_BEEF || obs_we !== 1'b1) begin $display("FAIL sw_wd_we: got %h/%b required deadbeef/1", obs_wd, obs_we); fails++; end
        tests++; if (obs_stall != 2) begin $display("FAIL sw_stall: got %0d required 2", obs_stall); fails++; end
        $display("[TB] SW 0x104 be=%b stall=%0d", obs_be, obs_stall);
        run(1'b1, 3'b000, 32'h0000_0107, 32'h0000_00A5, 32'h0, 0);
        tests++; if (obs_be !== 4'b1000 || obs_wd !== 32'hA5A5_A5A5) begin $display("FAIL sb_be_wd: got %b/%h required 1000/a5a5a5a5", obs_be, obs_wd); fails++; end
        tests++; if (obs_we !== 1'b1 || obs_addr !== 32'h104) begin $display("FAIL sb_we_addr: got %b/%h required 1/00000104", obs_we, obs_addr); fails++; end
        $display("[TB] SB 0x107 be=%b wd=%h", obs_be, obs_wd);
        run(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 2);
        tests++; if (obs_be !== 4'b1100 || obs_wd !== 32'hABCD_ABCD) begin $display("FAIL sh_be_wd: got %b/%h required 1100/abcdabcd", obs_be, obs_wd); fails++; end
        tests++; if (obs_stall != 4) begin $display("FAIL sh_stall: got %0d required 4", obs_stall); fails++; end
        $display("[TB] SH 0x102 be=%b wd=%h stall=%0d", obs_be, obs_wd, obs_stall);
    endtask

    task automatic test_load_byte();
        sel = 0;
        run(1'b0, 3'b000, 32'h0000_0102, 32'h0, 32'h0080_0000, 0);
        tests++; if (obs_rd !== 32'hFFFF_FF80) begin $display("FAIL lb_rd: got %h required ffffff80", obs_rd); fails++; end
        tests++; if (obs_be !== 4'b0100 || obs_we !== 1'b0) begin $display("FAIL lb_be_we: got %b/%b required 0100/0", obs_be, obs_we); fails++; end
        $display("[TB] LB 0x102 rd=%h", obs_rd);
        run(1'b0, 3'b100, 32'h0000_0102, 32'h0, 32'h0080_0000, 0);
        tests++; if (obs_rd !== 32'h0000_0080) begin $display("FAIL lbu_rd: got %h required 00000080", obs_rd); fails++; end
        $display("[TB] LBU 0x102 rd=%h", obs_rd);
    endtask

    task automatic test_load_half();
        sel = 0;
        run(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hBEEF_1234, 5);
        tests++; if (obs_rd !== 32'h0000_BEEF) begin $display("FAIL lhu_rd: got %h required 0000beef", obs_rd); fails++; end
        tests++; if (obs_stall != 7) begin $display("FAIL lhu_stall: got %0d required 7", obs_stall); fails++; end
        tests++; if (obs_be !== 4'b1100 || obs_addr !== 32'h0) begin $display("FAIL lhu_be_addr: got %b/%h required 1100/00000000", obs_be, obs_addr); fails++; end
        $display("[TB] LHU 0x002 rd=%h stall=%0d", obs_rd, obs_stall);
        run(1'b0, 3'b001, 32'h0000_0010, 32'h0, 32'h1234_8001, 0);
        tests++; if (obs_rd !== 32'hFFFF_8001 || obs_be !== 4'b0011) begin $display("FAIL lh_rd_be: got %h/%b required ffff8001/0011", obs_rd, obs_be); fails++; end
        $display("[TB] LH 0x010 rd=%h", obs_rd);
    endtask

    task automatic test_load_word();
        sel = 0;
        run(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hCAFE_F00D, 1);
        tests++; if (obs_rd !== 32'hCAFE_F00D) begin $display("FAIL lw_rd: got %h required cafef00d", obs_rd); fails++; end
        tests++; if (obs_be !== 4'b1111 || obs_addr !== 32'h100) begin $display("FAIL lw_be_addr: got %b/%h required 1111/00000100", obs_be, obs_addr); fails++; end
        tests++; if (obs_mis !== 1'b0 || obs_err !== 1'b0) begin $display("FAIL lw_mis_err: got %b/%b required 0/0", obs_mis, obs_err); fails++; end
        $display("[TB] LW 0x101 rd=%h be=%b", obs_rd, obs_be);
    endtask

    task automatic test_unsupported();
        sel = 0;
        run(1'b0, 3'b011, 32'h0000_0200, 32'h0, 32'hFFFF_FFFF, 0);
        tests++; if (obs_be !== 4'b0000 || obs_rd !== 32'h0) begin $display("FAIL bad_size: got be=%b rd=%h required 0000/00000000", obs_be, obs_rd); fails++; end
        tests++; if (obs_stall != 2) begin $display("FAIL bad_size_stall: got %0d required 2", obs_stall); fails++; end
        $display("[TB] size 011 be=%b rd=%h", obs_be, obs_rd);
    endtask

    task automatic test_timeout();
        sel = 1;
        run(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1122_3344, 0);
        tests++; if (obs_rd !== 32'h1122_3344) begin $display("FAIL to_pre_rd: got %h required 11223344", obs_rd); fails++; end
        run(1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'h5566_7788, 99);
        tests++; if (obs_err !== 1'b1 || obs_rd !== 32'h0) begin $display("FAIL to_abort: got err=%b rd=%h required 1/00000000", obs_err, obs_rd); fails++; end
        tests++; if (obs_stall != 5) begin $display("FAIL to_stall: got %0d required 5", obs_stall); fails++; end
        tests++; if (v_err !== 1'b0 || v_mreq !== 1'b0) begin $display("FAIL to_pulse: got err=%b req=%b required 0/0", v_err, v_mreq); fails++; end
        $display("[TB] timeout err=%b stall=%0d", obs_err, obs_stall);
        run(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_0000, 3);
        tests++; if (obs_err !== 1'b0 || obs_rd !== 32'hFFFF_8001) begin $display("FAIL to_edge: got err=%b rd=%h required 0/ffff8001", obs_err, obs_rd); fails++; end
        $display("[TB] ready at limit err=%b rd=%h", obs_err, obs_rd);
    endtask

    task automatic test_reset_mid();
        sel = 0;
        c_we = 1'b0; c_size = 3'b010; c_addr = 32'h0000_0300; rdy = 1'b0; c_req = 1'b1;
        @(posedge clk); #1;
        tests++; if (v_mreq !== 1'b1) begin $display("FAIL mid_req_up: got %b required 1", v_mreq); fails++; end
        #2; rst = 1'b1; #1;
        tests++; if (v_mreq !== 1'b0 || v_stall !== 1'b1) begin $display("FAIL mid_rst: got req=%b stall=%b required 0/1", v_mreq, v_stall); fails++; end
        c_req = 1'b0; #1;
        tests++; if (v_stall !== 1'b0) begin $display("FAIL mid_rst_idle: got %b required 0", v_stall); fails++; end
        @(posedge clk); #3; rst = 1'b0;
        @(posedge clk); #1;
        $display("[TB] async reset mid-transaction req=%b", v_mreq);
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_byte();
        test_load_half();
        test_load_word();
        test_unsupported();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
